// File: rtl/posit_defines.sv
// Shared constants, the serialized accumulator value layout and helpers
// for the posit16 (es=2) output stage.
package posit_defines;

  // Fraction width of the raw accumulator value (hidden bit excluded).
  localparam int FBITS_ACCUM = 24;
  // {sgn, scale[7:0], fraction, inf, zero}
  localparam int POSIT_SERIALIZED_WIDTH_ACCUM_ES2 = 1 + 8 + FBITS_ACCUM + 2;

  typedef struct packed {
    logic                   sgn;
    logic [7:0]             scale;     // two's complement
    logic [FBITS_ACCUM-1:0] fraction;
    logic                   inf;
    logic                   zero;
  } value_accum;

  localparam logic [15:0] POSIT16_ES2_MAXPOS    = 16'h7FFF;
  localparam logic [15:0] POSIT16_ES2_MINPOS    = 16'h0001;
  localparam logic [15:0] POSIT16_NAR           = 16'h8000;
  localparam int          POSIT16_ES2_MAX_SCALE = 56;

  // Largest regime shift after the scale clamp (|k| <= 14).
  localparam int REGIME_SHIFT_MAX = 14;
  // Working field: 2 regime seed bits, 2 exponent bits, fraction, shift room.
  localparam int FIELD_W = 4 + FBITS_ACCUM + REGIME_SHIFT_MAX;

  // How a value is turned into a posit once it leaves the unpack stage.
  typedef enum logic [2:0] {
    KIND_NORMAL,
    KIND_NAR,
    KIND_ZERO,
    KIND_SAT_MAX,
    KIND_SAT_MIN
  } round_kind_e;

  // Logical right shift that fills the vacated MSBs with 'fill'.
  function automatic logic [FIELD_W-1:0] shift_right(input logic [FIELD_W-1:0] val,
                                                     input logic [3:0]         amt,
                                                     input logic               fill);
    logic [FIELD_W-1:0] mask;
    mask = ~({FIELD_W{1'b1}} >> amt);
    return (val >> amt) | (fill ? mask : '0);
  endfunction

endpackage

// File: rtl/posit_accum_round_16_rne.sv
// Combinational 15-bit round-to-nearest-even incrementer. The result is
// kept inside [minpos, maxpos] so a nonzero value never becomes 0 or NaR.
module posit_round_rne
  import posit_defines::*;
(
  input  logic [14:0] mag,
  input  logic        guard,
  input  logic        sticky,
  output logic [14:0] rounded
);

  logic [15:0] sum;
  logic        inc;

  // Round up on more-than-half, or on an exact half when the lsb is odd.
  always_comb begin
    inc     = guard & (mag[0] | sticky);
    sum     = {1'b0, mag} + {15'd0, inc};
    rounded = sum[14:0];
    if (sum[15]) begin
      rounded = POSIT16_ES2_MAXPOS[14:0];
    end else if (sum[14:0] == 15'd0) begin
      rounded = POSIT16_ES2_MINPOS[14:0];
    end
  end

endmodule

// File: rtl/posit_accum_round_16.sv
// Three-stage encoder from the raw accumulator value to a posit16 (es=2):
// S1 unpack/clamp, S2 regime placement and guard/sticky, S3 round and sign.
module posit_accum_round_16
  import posit_defines::*;
#(
  parameter int N  = 16,
  parameter int ES = 2
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        in_valid,
  input  logic [POSIT_SERIALIZED_WIDTH_ACCUM_ES2-1:0] in_data,
  input  logic                                        in_truncated,
  output logic                                        out_valid,
  output logic [N-1:0]                                out_posit,
  output logic                                        out_inexact,
  output logic                                        out_nar
);

  value_accum        in_v;
  logic signed [7:0] in_scale;
  round_kind_e       s1_kind_next;

  assign in_v     = value_accum'(in_data);
  assign in_scale = $signed(in_v.scale);

  // ---------------- S1: unpack, special cases, scale clamp -------------
  logic                   s1_valid_reg;
  round_kind_e            s1_kind_reg;
  logic                   s1_sgn_reg;
  logic                   s1_kneg_reg;
  logic [3:0]             s1_amt_reg;
  logic [ES-1:0]          s1_e_reg;
  logic [FBITS_ACCUM-1:0] s1_frac_reg;
  logic                   s1_trunc_reg;

  // Classify the incoming value; inf wins over zero, both over the clamp.
  always_comb begin
    s1_kind_next = KIND_NORMAL;
    if (in_v.inf) begin
      s1_kind_next = KIND_NAR;
    end else if (in_v.zero) begin
      s1_kind_next = KIND_ZERO;
    end else if (int'(in_scale) > POSIT16_ES2_MAX_SCALE) begin
      s1_kind_next = KIND_SAT_MAX;
    end else if (int'(in_scale) < -POSIT16_ES2_MAX_SCALE) begin
      s1_kind_next = KIND_SAT_MIN;
    end
  end

  // Stage-1 valid; anything other than a clean 1 is treated as idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
    end else if (in_valid) begin
      s1_valid_reg <= 1'b1;
    end else begin
      s1_valid_reg <= 1'b0;
    end
  end

  // Stage-1 data. k = scale>>>2 fits in 5 bits once clamped, so its sign is
  // scale[7] and its low bits are scale[5:2]. The regime shift is k for
  // k>=0 and -k-1 (= ~k) for k<0.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      s1_kind_reg  <= s1_kind_next;
      s1_sgn_reg   <= in_v.sgn;
      s1_kneg_reg  <= in_scale[7];
      s1_amt_reg   <= in_scale[5:2] ^ {4{in_scale[7]}};
      s1_e_reg     <= in_scale[ES-1:0];
      s1_frac_reg  <= in_v.fraction;
      s1_trunc_reg <= in_truncated;
    end
  end

  // ---------------- S2: regime placement, guard and sticky -------------
  logic               s2_valid_reg;
  round_kind_e        s2_kind_reg;
  logic               s2_sgn_reg;
  logic [14:0]        s2_mag_reg;
  logic               s2_guard_reg;
  logic               s2_sticky_reg;
  logic               s2_trunc_reg;
  logic               s2_clamp_reg;
  logic [FIELD_W-1:0] s2_field;
  logic [14:0]        s2_mag_next;
  logic               s2_guard_next;
  logic               s2_sticky_next;
  logic               s2_clamp_next;

  // Seed "10" (k>=0) or "01" (k<0) ahead of e and fraction, then shift in
  // copies of the leading regime bit to stretch the run to its length.
  always_comb begin
    s2_field = shift_right({~s1_kneg_reg, s1_kneg_reg, s1_e_reg, s1_frac_reg,
                            {REGIME_SHIFT_MAX{1'b0}}},
                           s1_amt_reg, ~s1_kneg_reg);
    s2_mag_next    = s2_field[FIELD_W-1 -: 15];
    s2_guard_next  = s2_field[FIELD_W-16];
    s2_sticky_next = |s2_field[FIELD_W-17:0];
    s2_clamp_next  = 1'b0;
    if (s1_kind_reg == KIND_SAT_MAX) begin
      s2_mag_next    = POSIT16_ES2_MAXPOS[14:0];
      s2_guard_next  = 1'b0;
      s2_sticky_next = 1'b0;
      s2_clamp_next  = 1'b1;
    end else if (s1_kind_reg == KIND_SAT_MIN) begin
      s2_mag_next    = POSIT16_ES2_MINPOS[14:0];
      s2_guard_next  = 1'b0;
      s2_sticky_next = 1'b0;
      s2_clamp_next  = 1'b1;
    end
  end

  // Stage-2 valid follows stage 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
    end else begin
      s2_valid_reg <= s1_valid_reg;
    end
  end

  // Stage-2 data loads only behind a valid stage-1 value.
  always_ff @(posedge clk) begin
    if (s1_valid_reg) begin
      s2_kind_reg   <= s1_kind_reg;
      s2_sgn_reg    <= s1_sgn_reg;
      s2_mag_reg    <= s2_mag_next;
      s2_guard_reg  <= s2_guard_next;
      s2_sticky_reg <= s2_sticky_next;
      s2_trunc_reg  <= s1_trunc_reg;
      s2_clamp_reg  <= s2_clamp_next;
    end
  end

  // ---------------- S3: round, sign, output register --------------------
  logic [14:0]  s3_rounded;
  logic [N-1:0] out_posit_next;
  logic         out_inexact_next;
  logic         out_nar_next;

  // Truncation from the accumulator only marks the result inexact; it never
  // steers the rounding direction.
  posit_round_rne u_round (
    .mag     (s2_mag_reg),
    .guard   (s2_guard_reg),
    .sticky  (s2_sticky_reg),
    .rounded (s3_rounded)
  );

  // Apply the sign and the NaR/zero overrides.
  always_comb begin
    out_posit_next   = s2_sgn_reg ? (~{1'b0, s3_rounded} + 16'd1) : {1'b0, s3_rounded};
    out_inexact_next = s2_guard_reg | s2_sticky_reg | s2_trunc_reg | s2_clamp_reg;
    out_nar_next     = 1'b0;
    if (s2_kind_reg == KIND_NAR) begin
      out_posit_next   = POSIT16_NAR;
      out_inexact_next = 1'b0;
      out_nar_next     = 1'b1;
    end else if (s2_kind_reg == KIND_ZERO) begin
      out_posit_next   = '0;
      out_inexact_next = s2_trunc_reg;
    end
  end

  // Output registers hold their last value between results.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_posit   <= '0;
      out_inexact <= 1'b0;
      out_nar     <= 1'b0;
    end else begin
      out_valid <= s2_valid_reg;
      if (s2_valid_reg) begin
        out_posit   <= out_posit_next;
        out_inexact <= out_inexact_next;
        out_nar     <= out_nar_next;
      end
    end
  end

endmodule
